y86_register_file: RTL and testbench
====================================

Name: y86_register_file

Overview:
- Architectural register file for the SEQ Y86-64 processor.
- Holds the 15 program registers %rax..%r14; register ID 4'hF means "no register".
- Decode stage reads it through two combinational ports (srcA/srcB → valA/valB).
- The write-back selector drives its two write ports, which update state on the rising clock edge.

Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 15, number of architectural registers (IDs 0..NREGS-1); ID 4'hF is the null register.
- RSP_INIT, 64'h0000_0000_0000_0000, reset value of %rsp (ID 4).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears the register file.
- wrEn  input  1  global write enable from the write-back selector.
- registernumber1  input  4  destination ID for write port 1 (valE path).
- registernumber2  input  4  destination ID for write port 2 (valM path).
- val_write1  input  WIDTH  data for write port 1.
- val_write2  input  WIDTH  data for write port 2.
- srcA  input  4  read port A register ID.
- srcB  input  4  read port B register ID.
- valA  output  WIDTH  read port A data.
- valB  output  WIDTH  read port B data.
- write_count  output  16  number of architectural register writes committed since reset; saturates.

Behaviour:
- Storage: NREGS × WIDTH flip-flops.
- Reset (asynchronous, active-high):
  - The instant reset rises, every register goes to 0, except ID 4, which takes RSP_INIT.
  - write_count goes to 0.
  - valA/valB reflect the reset contents combinationally.
  - Held while reset=1; writes are ignored.
  - Reset asserted between edges discards nothing pending; there is no buffered state.
- Write (rising clk edge, reset=0, wrEn=1):
  - Port 1: if registernumber1 < NREGS, R[registernumber1] ← val_write1.
  - Port 2: if registernumber2 < NREGS, R[registernumber2] ← val_write2.
  - ID 4'hF on either port: that port does nothing.
  - Both ports target the same ID: port 2 wins (popq %rsp semantics: valM overrides valE).
  - wrEn=0: no register changes, regardless of port IDs.
- Read (combinational, zero latency):
  - valA = R[srcA]; valB = R[srcB].
  - srcA/srcB = 4'hF returns 0.
  - Without the bypass feature, a read in the same cycle as a write returns the old value; the new value appears after the edge.
- write_count:
  - Increments on each edge by the number of ports that actually wrote (0, 1 or 2).
  - A same-ID collision counts 1.
  - Saturates at 16'hFFFF with no wrap.
- Width rules: no truncation or sign handling; data is stored verbatim.
- The upstream selector never drives IDs in range but ≥ NREGS when NREGS=15; any ID ≥ NREGS is treated as null.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read ports forward write data combinationally.
  - If wrEn=1 and srcA equals a valid write ID, valA = that port's write data (port 2 has priority over port 1). Same rule for valB.
  - Forwarding is inactive while reset=1.
- Undefined: plain array read as described above; no forwarding logic is synthesized.

Test Plan:
- Reset check: assert reset mid-cycle with RSP_INIT=64'h200 → valA for srcA=4 reads 64'h200 immediately, srcA=0 reads 0, write_count=0, before any clk edge.
- Single write: wrEn=1, registernumber1=0, val_write1=64'hDEAD, registernumber2=F → after edge, srcA=0 reads 64'hDEAD and write_count=1; registernumber2=F leaves R[15-range] untouched, srcB=F reads 0.
- Dual write (popq %rbx): registernumber1=4, val_write1=64'h108, registernumber2=3, val_write2=64'h55 → after one edge R4=64'h108, R3=64'h55, write_count +2.
- Collision (popq %rsp): both IDs=4, val_write1=64'h108, val_write2=64'h77 → R4=64'h77, write_count +1.
- wrEn=0 with registernumber1=2, val_write1=64'h1 → R2 unchanged after edge, write_count unchanged.
- Read-during-write: R5=64'hA, write R5←64'hB while srcA=5 → before edge valA=64'hA without REGFILE_BYPASS_EN, 64'hB with it; after edge 64'hB in both builds.

Source files
------------

// File: rtl/y86_register_file.sv
// SEQ Y86-64 architectural register file: 15 x WIDTH, two write ports, two
// combinational read ports. Define REGFILE_BYPASS_EN to forward write data to the read ports.
module y86_regfile_entry #(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)   q <= RST_VAL;
    else if (we) q <= d;
endmodule

module y86_register_file #(
  parameter int               WIDTH    = 64,
  parameter int               NREGS    = 15,
  parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [3:0]       registernumber1,
  input  logic [3:0]       registernumber2,
  input  logic [WIDTH-1:0] val_write1,
  input  logic [WIDTH-1:0] val_write2,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic [15:0]      write_count
);
  localparam logic [4:0] NREGS5 = 5'(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            hit1, hit2;
  logic                        p1_ok, p2_ok, coll;
  logic [1:0]                  inc;
  logic [16:0]                 cnt_sum;

  // Any ID at or above NREGS (including 4'hF) is the null register.
  assign p1_ok = wrEn && ({1'b0, registernumber1} < NREGS5);
  assign p2_ok = wrEn && ({1'b0, registernumber2} < NREGS5);
  assign coll  = p1_ok && p2_ok && (registernumber1 == registernumber2);

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
      localparam logic [WIDTH-1:0] RV = (i == 4) ? RSP_INIT : '0;
      assign hit1[i] = p1_ok && (registernumber1 == 4'(i));
      assign hit2[i] = p2_ok && (registernumber2 == 4'(i));
      // Port 2 (valM) wins a collision so popq %rsp loads the popped value.
      y86_regfile_entry #(.WIDTH(WIDTH), .RST_VAL(RV)) u_ent (
        .clk   (clk),
        .reset (reset),
        .we    (hit1[i] | hit2[i]),
        .d     (hit2[i] ? val_write2 : val_write1),
        .q     (regs[i])
      );
    end
  endgenerate

  function automatic logic [WIDTH-1:0] rd(input logic [3:0] src);
    logic [WIDTH-1:0] v;
    v = '0;
    if ({1'b0, src} < NREGS5) v = regs[src];
`ifdef REGFILE_BYPASS_EN
    if (!reset) begin
      if (p2_ok && registernumber2 == src)      v = val_write2;
      else if (p1_ok && registernumber1 == src) v = val_write1;
    end
`endif
    return v;
  endfunction

  assign valA = rd(srcA);
  assign valB = rd(srcB);

  always_comb begin
    inc = 2'd0;
    if (p1_ok && p2_ok && !coll) inc = 2'd2;
    else if (p1_ok || p2_ok)     inc = 2'd1;
  end

  assign cnt_sum = {1'b0, write_count} + {15'd0, inc};

  always_ff @(posedge clk or posedge reset)
    if (reset)           write_count <= '0;
    else if (cnt_sum[16]) write_count <= 16'hFFFF;
    else                 write_count <= cnt_sum[15:0];
endmodule

// File: tb/tb_y86_register_file.sv
// Scoreboard bench for y86_register_file: stimulus queues expected reads,
// a monitor process compares them when a sample strobe fires.
module tb_y86_register_file;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wrEn = 1'b0;
  logic [3:0]  registernumber1 = 4'hF, registernumber2 = 4'hF;
  logic [63:0] val_write1 = '0, val_write2 = '0;
  logic [3:0]  srcA = 4'h0, srcB = 4'h0;
  logic [63:0] valA, valB;
  logic [15:0] write_count;

  y86_register_file #(.WIDTH(64), .NREGS(15), .RSP_INIT(64'h200)) dut (
    .clk(clk), .reset(reset), .wrEn(wrEn),
    .registernumber1(registernumber1), .registernumber2(registernumber2),
    .val_write1(val_write1), .val_write2(val_write2),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] ea, eb;
    logic [15:0] ec;
  } exp_t;

  exp_t q[$];
  event smp;
  int   nvec = 0, nerr = 0;

  // Monitor: the DUT's outputs are combinational, so each strobe means "outputs are presentable".
  initial forever begin
    exp_t e;
    @(smp);
    if (q.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard_underflow: strobe with no expected entry");
    end else begin
      e = q.pop_front();
      nvec++;
      if (valA !== e.ea) begin nerr++; $display("FAIL %s.valA: got %h want %h", e.name, valA, e.ea); end
      nvec++;
      if (valB !== e.eb) begin nerr++; $display("FAIL %s.valB: got %h want %h", e.name, valB, e.eb); end
      nvec++;
      if (write_count !== e.ec) begin nerr++; $display("FAIL %s.count: got %0d want %0d", e.name, write_count, e.ec); end
    end
  end

  task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] b,
                     input logic [63:0] ea, input logic [63:0] eb, input logic [15:0] ec);
    exp_t e;
    srcA = a; srcB = b;
    #1;
    e.name = nm; e.ea = ea; e.eb = eb; e.ec = ec;
    q.push_back(e);
    ->smp;
    #1;
  endtask

  task automatic wr(input logic en, input logic [3:0] r1, input logic [63:0] v1,
                    input logic [3:0] r2, input logic [63:0] v2);
    wrEn = en; registernumber1 = r1; val_write1 = v1;
    registernumber2 = r2; val_write2 = v2;
  endtask

  task automatic edge_then_idle();
    @(posedge clk); @(negedge clk);
    wr(1'b0, 4'hF, '0, 4'hF, '0);
  endtask

  initial begin
    logic [63:0] rdw_exp;
    // Reset mid-cycle, before any clock edge.
    #2 reset = 1'b1;
    chk("reset", 4'd4, 4'd0, 64'h200, 64'h0, 16'd0);
    // Writes are ignored while reset is held.
    wr(1'b1, 4'd0, 64'hFF, 4'd1, 64'hEE);
    @(posedge clk); @(negedge clk);
    chk("reset_hold", 4'd0, 4'd1, 64'h0, 64'h0, 16'd0);
    wr(1'b0, 4'hF, '0, 4'hF, '0);
    reset = 1'b0;

    // Single write, port 2 null.
    wr(1'b1, 4'd0, 64'hDEAD, 4'hF, 64'h1234);
    edge_then_idle();
    chk("single", 4'd0, 4'hF, 64'hDEAD, 64'h0, 16'd1);
    chk("untouched", 4'd14, 4'd1, 64'h0, 64'h0, 16'd1);

    // popq %rbx: both ports, distinct IDs.
    wr(1'b1, 4'd4, 64'h108, 4'd3, 64'h55);
    edge_then_idle();
    chk("dual", 4'd4, 4'd3, 64'h108, 64'h55, 16'd3);

    // popq %rsp: collision, port 2 wins, counts once.
    wr(1'b1, 4'd4, 64'h108, 4'd4, 64'h77);
    edge_then_idle();
    chk("collision", 4'd4, 4'd3, 64'h77, 64'h55, 16'd4);

    // wrEn low: nothing changes.
    wr(1'b0, 4'd2, 64'h1, 4'd3, 64'h99);
    edge_then_idle();
    chk("wren_low", 4'd2, 4'd3, 64'h0, 64'h55, 16'd4);

    // Port 1 null, port 2 writes.
    wr(1'b1, 4'hF, 64'h5555, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF);
    edge_then_idle();
    chk("port2_only", 4'd14, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD, 16'd5);

    // Read during write.
    wr(1'b1, 4'd5, 64'hA, 4'hF, '0);
    edge_then_idle();
    chk("r5_init", 4'd5, 4'd5, 64'hA, 64'hA, 16'd6);
    wr(1'b1, 4'd5, 64'hB, 4'hF, '0);
`ifdef REGFILE_BYPASS_EN
    rdw_exp = 64'hB;
`else
    rdw_exp = 64'hA;
`endif
    chk("rdw_before", 4'd5, 4'd5, rdw_exp, rdw_exp, 16'd6);
    edge_then_idle();
    chk("rdw_after", 4'd5, 4'd5, 64'hB, 64'hB, 16'd7);

    // Saturation: dual writes until the counter pins at FFFF.
    wr(1'b1, 4'd6, 64'h6, 4'd7, 64'h7);
    repeat (32770) @(posedge clk);
    @(negedge clk);
    chk("saturate", 4'd6, 4'd7, 64'h6, 64'h7, 16'hFFFF);
    @(posedge clk); @(negedge clk);
    chk("sat_hold", 4'd6, 4'd7, 64'h6, 64'h7, 16'hFFFF);
    wr(1'b0, 4'hF, '0, 4'hF, '0);

    // Second asynchronous reset clears everything mid-cycle.
    #1 reset = 1'b1;
    chk("reset2", 4'd4, 4'd0, 64'h200, 64'h0, 16'd0);
    chk("reset2_b", 4'd5, 4'd6, 64'h0, 64'h0, 16'd0);
    reset = 1'b0;

    #5;
    if (q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
